// File: rtl/spawn_sched.sv
// Round-robin spawn scheduler: every SPAWN_PERIOD frames it loads the next free slot's x column.
// Optional feature macro: SPAWN_NO_REPEAT_EN (consecutive spawns never share a column).
module spawn_sched #(
    parameter int          NUM_SLOTS    = 10,
    parameter int          SPAWN_PERIOD = 50,
    parameter logic [7:0]  LFSR_SEED    = 8'hA5
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 enable,
    input  logic                 frame_tick,
    input  logic [NUM_SLOTS-1:0] slot_free,
    output logic [NUM_SLOTS-1:0] load_x,
    output logic [3:0]           rand_int,
    output logic [7:0]           spawn_cnt,
    output logic [7:0]           miss_cnt
);

    // state | meaning
    // IDLE  | scheduling disabled, tick count cleared
    // WAIT  | counting frame ticks toward the next attempt
    // PICK  | testing slot_free[ptr], one slot per clock, one lap max
    // LOAD  | one-hot load_x pulse is on the outputs this cycle

    localparam int PW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int TW = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;
    localparam logic [PW-1:0] PTR_LAST  = PW'(NUM_SLOTS - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(SPAWN_PERIOD - 1);

    typedef enum logic [1:0] {IDLE, WAIT, PICK, LOAD} state_t;

    state_t          state;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   ptr_next;
    logic [PW-1:0]   scan;
    logic [TW-1:0]   tick_cnt;
    logic [7:0]      lfsr;
    logic [3:0]      r_fold;
    logic [3:0]      r_pick;

    assign ptr_next = (ptr == PTR_LAST) ? '0 : ptr + PW'(1);

    always_comb begin
        r_fold = (lfsr[3:0] == 4'd15) ? 4'd7 : lfsr[3:0];
`ifdef SPAWN_NO_REPEAT_EN
        r_pick = (r_fold != rand_int) ? r_fold :
                 (r_fold == 4'd14)    ? 4'd0 : r_fold + 4'd1;
`else
        r_pick = r_fold;
`endif
    end

    // x^8+x^6+x^5+x^4+1, free-running regardless of FSM state
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            ptr       <= '0;
            scan      <= '0;
            tick_cnt  <= '0;
            load_x    <= '0;
            rand_int  <= '0;
            spawn_cnt <= '0;
            miss_cnt  <= '0;
        end else begin
            load_x <= '0;
            case (state)
                IDLE: begin
                    tick_cnt <= '0;
                    if (enable) state <= WAIT;
                end
                WAIT: begin
                    if (!enable) begin
                        state    <= IDLE;
                        tick_cnt <= '0;
                    end else if (frame_tick) begin
                        if (tick_cnt == TICK_LAST) begin
                            tick_cnt <= '0;
                            scan     <= '0;
                            state    <= PICK;
                        end else begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end
                end
                PICK: begin
                    if (!enable) begin
                        state    <= IDLE;
                        tick_cnt <= '0;
                    end else if (slot_free[ptr]) begin
                        rand_int <= r_pick;
                        load_x   <= NUM_SLOTS'(1) << ptr;
                        state    <= LOAD;
                    end else begin
                        ptr  <= ptr_next;
                        scan <= scan + PW'(1);
                        // a full lap of misses leaves ptr where it started
                        if (scan == PTR_LAST) begin
                            if (miss_cnt != 8'hFF) miss_cnt <= miss_cnt + 8'd1;
                            state <= WAIT;
                        end
                    end
                end
                LOAD: begin
                    spawn_cnt <= spawn_cnt + 8'd1;
                    ptr       <= ptr_next;
                    state     <= enable ? WAIT : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spawn_sched.sv
// Randomized bench for spawn_sched against a transaction-level model of attempts and spawns.
module tb_spawn_sched;

    localparam int         N    = 10;
    localparam int         P    = 3;
    localparam logic [7:0] SEED = 8'hA5;
`ifdef SPAWN_NO_REPEAT_EN
    localparam bit NO_REP = 1'b1;
`else
    localparam bit NO_REP = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         enable = 1'b0;
    logic         frame_tick = 1'b0;
    logic [N-1:0] slot_free = '1;
    logic [N-1:0] load_x;
    logic [3:0]   rand_int;
    logic [7:0]   spawn_cnt;
    logic [7:0]   miss_cnt;

    spawn_sched #(.NUM_SLOTS(N), .SPAWN_PERIOD(P), .LFSR_SEED(SEED)) dut (
        .clk(clk), .resetn(resetn), .enable(enable), .frame_tick(frame_tick),
        .slot_free(slot_free), .load_x(load_x), .rand_int(rand_int),
        .spawn_cnt(spawn_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] lfsr_m;
    int ptr_m, spawn_m, miss_m, ri_m, ticks_m;
    int attempts = 0;
    int total_spawns = 0;
    bit in_wait;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    function automatic int column_of(input logic [7:0] v, input int last);
        int r;
        r = int'(v[3:0]);
        if (r == 15) r = 7;
        if (NO_REP && r == last) r = (r == 14) ? 0 : r + 1;
        return r;
    endfunction

    task automatic model_reset();
        lfsr_m  = SEED;
        ptr_m   = 0;
        spawn_m = 0;
        miss_m  = 0;
        ri_m    = 0;
        ticks_m = 0;
        in_wait = 1'b0;
    endtask

    // one clock; outputs sampled 1 time unit after the edge
    task automatic cycle(input bit ft, input bit latch, input int exp_load);
        frame_tick = ft;
        @(posedge clk);
        if (latch) ri_m = column_of(lfsr_m, ri_m);
        lfsr_m = lfsr_next(lfsr_m);
        #1;
        check_eq("load_x", load_x, exp_load);
        check_eq("rand_int", rand_int, ri_m);
        frame_tick = 1'b0;
    endtask

    task automatic mid_reset();
        #2;
        resetn = 1'b0;
        model_reset();
        #1;
        check_eq("rst_load_x", load_x, 0);
        check_eq("rst_rand_int", rand_int, 0);
        check_eq("rst_spawn_cnt", spawn_cnt, 0);
        check_eq("rst_miss_cnt", miss_cnt, 0);
        @(posedge clk);
        #1;
        check_eq("rst_hold_load_x", load_x, 0);
        resetn = 1'b1;
    endtask

    // an attempt begins right after the qualifying tick; abort_at inserts a reset before that cycle
    task automatic run_attempt(input int abort_at);
        int  k;
        int  s;
        bit  hit;
        attempts++;
        hit = 1'b0;
        k = 0;
        for (int i = 0; i < N; i++)
            if (!hit && slot_free[(ptr_m + i) % N]) begin hit = 1'b1; k = i; end
        if (hit) begin
            s = (ptr_m + k) % N;
            for (int i = 0; i <= k + 1; i++) begin
                if (i == abort_at) begin mid_reset(); return; end
                if (i == k) begin
                    cycle(1'($urandom_range(1)), 1'b1, 1 << s);
                    check_eq("rand_max", 32'(rand_int <= 4'd14), 1);
                end else begin
                    cycle(1'($urandom_range(1)), 1'b0, 0);
                end
            end
            spawn_m = (spawn_m + 1) % 256;
            ptr_m   = (s + 1) % N;
            total_spawns++;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (i == abort_at) begin mid_reset(); return; end
                cycle(1'($urandom_range(1)), 1'b0, 0);
            end
            if (miss_m < 255) miss_m++;
        end
        check_eq("spawn_cnt", spawn_cnt, spawn_m);
        check_eq("miss_cnt", miss_cnt, miss_m);
    endtask

    task automatic step(input bit ft, input int abort_at);
        bit fire;
        fire = 1'b0;
        if (!enable) begin
            in_wait = 1'b0;
            ticks_m = 0;
        end else if (!in_wait) begin
            in_wait = 1'b1;
        end else if (ft) begin
            ticks_m++;
            if (ticks_m == P) begin ticks_m = 0; fire = 1'b1; end
        end
        cycle(ft, 1'b0, 0);
        if (fire) run_attempt(abort_at);
    endtask

    initial begin
        int base;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_load_x", load_x, 0);
        check_eq("reset_rand_int", rand_int, 0);
        check_eq("reset_spawn_cnt", spawn_cnt, 0);
        check_eq("reset_miss_cnt", miss_cnt, 0);
        resetn = 1'b1;

        // back-to-back ticks, all slots free: pulses walk 0x001,0x002,0x004,0x008
        enable = 1'b1;
        slot_free = '1;
        for (int i = 0; i < 40 && spawn_m < 4; i++) step(1'b1, -1);
        check_eq("t1_spawns", spawn_cnt, 4);

        // only the top slot free: nine misses in PICK then 0x200, ptr wraps to 0
        mid_reset();
        slot_free = 10'b10_0000_0000;
        for (int i = 0; i < 40 && spawn_m < 1; i++) step(1'b1, -1);
        slot_free = '1;
        for (int i = 0; i < 40 && spawn_m < 2; i++) step(1'b1, -1);
        check_eq("t2_spawns", spawn_cnt, 2);

        // no free slot: miss counter saturates
        slot_free = '0;
        base = attempts;
        for (int i = 0; i < 2000 && attempts < base + 300; i++) step(1'b1, -1);
        check_eq("t3_miss_sat", miss_cnt, 255);
        check_eq("t3_no_spawn", spawn_cnt, 2);

        // reset during PICK, then during LOAD; next spawn restarts at slot 0
        base = attempts;
        for (int i = 0; i < 40 && attempts == base; i++) step(1'b1, 2);
        enable = 1'b1;
        slot_free = '1;
        for (int i = 0; i < 40 && spawn_m < 1; i++) step(1'b1, -1);
        base = attempts;
        for (int i = 0; i < 40 && attempts == base; i++) step(1'b1, 1);
        for (int i = 0; i < 40 && spawn_m < 1; i++) step(1'b1, -1);
        check_eq("t5_spawns", spawn_cnt, 1);

        // enable dropped with two ticks counted: full period counted again after re-enable
        mid_reset();
        step(1'b0, -1);
        step(1'b1, -1);
        step(1'b1, -1);
        enable = 1'b0;
        repeat (5) step(1'b1, -1);
        enable = 1'b1;
        step(1'b1, -1);
        step(1'b1, -1);
        step(1'b1, -1);
        check_eq("t6_no_spawn_yet", spawn_cnt, 0);
        step(1'b1, -1);
        check_eq("t6_spawn", spawn_cnt, 1);

        // random sweep: 1000 spawns with random ticks, slot occupancy and enable drops
        base = total_spawns;
        for (int i = 0; i < 40000 && total_spawns < base + 1000; i++) begin
            enable    = ($urandom_range(49) != 0);
            slot_free = N'($urandom);
            step(1'($urandom_range(1)), -1);
        end
        check_eq("sweep_done", 32'(total_spawns >= base + 1000), 1);
        check_eq("sweep_spawn_cnt", spawn_cnt, spawn_m);
        check_eq("sweep_miss_cnt", miss_cnt, miss_m);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
